reservation_station: RTL and testbench
======================================

# reservation_station

Per-functional-unit reservation station for the out-of-order core. It accepts dispatched ops whose source operands are either already-valid values or pending results tagged by GPR index. Pending operands are woken by snooping the result broadcast (CDB). Ready ops are issued through a registered valid/ready output stage to the functional unit. The block sits between dispatch/rename and the execute unit.

## Interface
- RS_SIZE, 2: number of entries (≥2)
- REG_SIZE, 64: operand/value width
- GPR_IDX_SIZE, 5: GPR index (tag) width, $clog2(32)
- OPC_SIZE, 4: opcode width, carried through untouched
- i_clk  in  1  clock; all state updates on posedge
- i_reset  in  1  synchronous, active-high reset
- i_flush  in  1  synchronous clear of all entries and the output stage; same effect as reset
- i_disp_valid  in  1  dispatch request
- o_disp_ready  out  1  an entry is free (combinational from registered occupancy)
- i_disp_opc  in  OPC_SIZE  opcode
- i_disp_dst  in  GPR_IDX_SIZE  destination GPR index, passed through
- i_disp_op{1,2}_valid  in  1  operand value already present
- i_disp_op{1,2}_gpr_idx  in  GPR_IDX_SIZE  producer tag when not valid
- i_disp_op{1,2}_value  in  REG_SIZE  operand value when valid
- i_cdb_valid  in  1  result broadcast this cycle
- i_cdb_gpr_idx  in  GPR_IDX_SIZE  broadcast tag
- i_cdb_value  in  REG_SIZE  broadcast value
- o_issue_valid  out  1  output stage holds an op
- i_issue_ready  in  1  functional unit accepts
- o_issue_opc / o_issue_dst / o_issue_op1 / o_issue_op2  out  OPC_SIZE / GPR_IDX_SIZE / REG_SIZE / REG_SIZE  issued op
- o_occupancy  out  $clog2(RS_SIZE+1)  busy entry count, registered

## Operation
- Entry state: busy, opc, dst, and two operands each {valid, gpr_idx, value}.
- Dispatch is accepted when i_disp_valid && o_disp_ready. The op writes the lowest-index non-busy entry.
- o_disp_ready = (o_occupancy != RS_SIZE). A slot freed by issue this cycle is not reusable until the next cycle.
- Dispatch bypass: if a dispatched operand is invalid and i_cdb_valid with a matching i_cdb_gpr_idx, the entry is written with valid=1 and value=i_cdb_value.
- Wakeup: every busy entry operand with valid=0 and a matching tag captures i_cdb_value and sets valid. All matching operands in all entries wake in the same cycle, including both operands of one entry.
- An operand already valid ignores the CDB, even if its stale gpr_idx matches.
- Ready = busy && op1.valid && op2.valid, evaluated on registered state. An operand woken this cycle is ready next cycle.
- Select: the lowest-index ready entry is chosen when the output stage is empty, or is being drained (o_issue_valid && i_issue_ready).
  - The selected entry moves into the output stage and its busy bit clears on the same edge.
- Output stage holds its contents stable while o_issue_valid && !i_issue_ready. o_issue_valid drops after a handshake with no new selection.
- o_occupancy: next = cur + dispatch_accepted − entry_selected. Simultaneous dispatch and select leave it unchanged.
- i_reset or i_flush: all busy=0, o_issue_valid=0, o_occupancy=0. Both override a same-cycle dispatch, CDB, or issue handshake. A flush mid-handshake discards the op.

## Timing
- Reset values:
  - o_issue_valid=0, o_occupancy=0, o_disp_ready=1.
  - o_issue_opc/dst/op1/op2 = 0.
- Dispatch with both operands valid in cycle N: entry busy in N+1, selected at the end of N+1, o_issue_valid=1 in N+2.
  - Minimum dispatch-to-issue latency is 2 cycles.
- Operand woken by the CDB in cycle N: earliest o_issue_valid in N+2.
- Throughput: one issue per cycle while i_issue_ready stays high and ready entries exist.
- Full: with o_occupancy=RS_SIZE, o_disp_ready=0; i_disp_valid is ignored and no state changes.
- Empty with no ready entries: the output stage drains and o_issue_valid=0.

## Test plan
- Reset then dispatch {op1 valid=5, op2 valid=7, dst=3}, i_issue_ready=1 -> o_issue_valid=1 exactly 2 cycles later with op1=5, op2=7, dst=3; o_occupancy returns to 0.
- Dispatch op1 waiting on gpr 9, op2 valid=1; CDB {9, 0x1234} 3 cycles later -> issue 2 cycles after the CDB with op1=0x1234; no issue before.
- Dispatch with op1 tag 4 while CDB {4, 42} is broadcast in the same cycle -> issue 2 cycles later with op1=42 (bypass).
- Fill RS_SIZE=2 with waiting ops -> o_disp_ready=0 and a third i_disp_valid is dropped. One CDB wakes both entries -> entry 0 issues, then entry 1; i_issue_ready held low for 3 cycles keeps outputs stable.
- Fill, hold i_issue_ready=1, assert dispatch in the same cycle as a select while full -> dispatch rejected that cycle, accepted the next; o_occupancy sequence 2,1,2.
- Assert i_flush while o_issue_valid=1 and entries are busy -> next cycle o_issue_valid=0, o_occupancy=0, o_disp_ready=1; a later CDB causes no issue.

Source files
------------

// File: rtl/reservation_station_if.sv
// Dispatch, result-broadcast and issue channels of one reservation station.
// The DUT side uses the slave modport.
interface reservation_station_if #(
  parameter int REG_SIZE     = 64,
  parameter int GPR_IDX_SIZE = 5,
  parameter int OPC_SIZE     = 4
);
  logic                    i_disp_valid;
  logic                    o_disp_ready;
  logic [OPC_SIZE-1:0]     i_disp_opc;
  logic [GPR_IDX_SIZE-1:0] i_disp_dst;
  logic                    i_disp_op1_valid;
  logic [GPR_IDX_SIZE-1:0] i_disp_op1_gpr_idx;
  logic [REG_SIZE-1:0]     i_disp_op1_value;
  logic                    i_disp_op2_valid;
  logic [GPR_IDX_SIZE-1:0] i_disp_op2_gpr_idx;
  logic [REG_SIZE-1:0]     i_disp_op2_value;
  logic                    i_cdb_valid;
  logic [GPR_IDX_SIZE-1:0] i_cdb_gpr_idx;
  logic [REG_SIZE-1:0]     i_cdb_value;
  logic                    o_issue_valid;
  logic                    i_issue_ready;
  logic [OPC_SIZE-1:0]     o_issue_opc;
  logic [GPR_IDX_SIZE-1:0] o_issue_dst;
  logic [REG_SIZE-1:0]     o_issue_op1;
  logic [REG_SIZE-1:0]     o_issue_op2;

  modport slave (
    input  i_disp_valid, i_disp_opc, i_disp_dst,
           i_disp_op1_valid, i_disp_op1_gpr_idx, i_disp_op1_value,
           i_disp_op2_valid, i_disp_op2_gpr_idx, i_disp_op2_value,
           i_cdb_valid, i_cdb_gpr_idx, i_cdb_value, i_issue_ready,
    output o_disp_ready, o_issue_valid, o_issue_opc, o_issue_dst,
           o_issue_op1, o_issue_op2
  );

  modport master (
    output i_disp_valid, i_disp_opc, i_disp_dst,
           i_disp_op1_valid, i_disp_op1_gpr_idx, i_disp_op1_value,
           i_disp_op2_valid, i_disp_op2_gpr_idx, i_disp_op2_value,
           i_cdb_valid, i_cdb_gpr_idx, i_cdb_value, i_issue_ready,
    input  o_disp_ready, o_issue_valid, o_issue_opc, o_issue_dst,
           o_issue_op1, o_issue_op2
  );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: entries wait for operands via CDB snooping, the lowest
// ready entry moves into a registered valid/ready issue stage.

module rs_entry #(
  parameter int REG_SIZE     = 64,
  parameter int GPR_IDX_SIZE = 5,
  parameter int OPC_SIZE     = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic                    sel,
  input  logic [OPC_SIZE-1:0]     wr_opc,
  input  logic [GPR_IDX_SIZE-1:0] wr_dst,
  input  logic                    wr_op1_valid,
  input  logic [GPR_IDX_SIZE-1:0] wr_op1_idx,
  input  logic [REG_SIZE-1:0]     wr_op1_value,
  input  logic                    wr_op2_valid,
  input  logic [GPR_IDX_SIZE-1:0] wr_op2_idx,
  input  logic [REG_SIZE-1:0]     wr_op2_value,
  input  logic                    cdb_valid,
  input  logic [GPR_IDX_SIZE-1:0] cdb_idx,
  input  logic [REG_SIZE-1:0]     cdb_value,
  output logic                    busy,
  output logic                    ready,
  output logic [OPC_SIZE-1:0]     opc,
  output logic [GPR_IDX_SIZE-1:0] dst,
  output logic [REG_SIZE-1:0]     op1_value,
  output logic [REG_SIZE-1:0]     op2_value
);
  typedef struct packed {
    logic                    valid;
    logic [GPR_IDX_SIZE-1:0] idx;
    logic [REG_SIZE-1:0]     value;
  } opnd_t;

  typedef struct packed {
    logic                    busy;
    logic [OPC_SIZE-1:0]     opc;
    logic [GPR_IDX_SIZE-1:0] dst;
    opnd_t                   op1;
    opnd_t                   op2;
  } ent_t;

  ent_t ent_q, ent_d;

  // Same rule serves wakeup of stored operands and dispatch-time bypass;
  // an operand that is already valid never looks at the CDB.
  function automatic opnd_t wake(input opnd_t o, input logic cv,
                                 input logic [GPR_IDX_SIZE-1:0] ct,
                                 input logic [REG_SIZE-1:0] cx);
    opnd_t r;
    r = o;
    if (!o.valid && cv && (o.idx == ct)) begin
      r.valid = 1'b1;
      r.value = cx;
    end
    return r;
  endfunction

  always_comb begin
    ent_d = ent_q;
    if (ent_q.busy) begin
      ent_d.op1 = wake(ent_q.op1, cdb_valid, cdb_idx, cdb_value);
      ent_d.op2 = wake(ent_q.op2, cdb_valid, cdb_idx, cdb_value);
      if (sel) ent_d.busy = 1'b0;
    end else if (wr_en) begin
      ent_d.busy = 1'b1;
      ent_d.opc  = wr_opc;
      ent_d.dst  = wr_dst;
      ent_d.op1  = wake({wr_op1_valid, wr_op1_idx, wr_op1_value},
                        cdb_valid, cdb_idx, cdb_value);
      ent_d.op2  = wake({wr_op2_valid, wr_op2_idx, wr_op2_value},
                        cdb_valid, cdb_idx, cdb_value);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) ent_q <= '0;
    else     ent_q <= ent_d;
  end

  assign busy      = ent_q.busy;
  assign ready     = ent_q.busy && ent_q.op1.valid && ent_q.op2.valid;
  assign opc       = ent_q.opc;
  assign dst       = ent_q.dst;
  assign op1_value = ent_q.op1.value;
  assign op2_value = ent_q.op2.value;
endmodule

module reservation_station #(
  parameter int RS_SIZE      = 2,
  parameter int REG_SIZE     = 64,
  parameter int GPR_IDX_SIZE = 5,
  parameter int OPC_SIZE     = 4
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_flush,
  reservation_station_if.slave           rs,
  output logic [$clog2(RS_SIZE+1)-1:0]   o_occupancy
);
  localparam int OCC_W = $clog2(RS_SIZE + 1);
  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic                    valid;
    logic [OPC_SIZE-1:0]     opc;
    logic [GPR_IDX_SIZE-1:0] dst;
    logic [REG_SIZE-1:0]     op1;
    logic [REG_SIZE-1:0]     op2;
  } iss_t;

  logic                                      clr;
  logic [RS_SIZE-1:0]                        e_busy, e_rdy;
  logic [RS_SIZE-1:0][OPC_SIZE-1:0]          e_opc;
  logic [RS_SIZE-1:0][GPR_IDX_SIZE-1:0]      e_dst;
  logic [RS_SIZE-1:0][REG_SIZE-1:0]          e_op1, e_op2;
  logic [RS_SIZE-1:0]                        alloc_oh, rdy_oh, wr_en, sel_oh;
  logic                                      found_a, found_s;
  logic [IDX_W-1:0]                          sel_idx;
  logic                                      disp_ready, disp_fire;
  logic                                      sel_en, sel_any;
  iss_t                                      iss_q, iss_d;
  logic [OCC_W-1:0]                          occ_q, occ_d;

  assign clr = i_reset || i_flush;

  // Ready mask comes from registered entry state, so a freshly written or
  // freshly woken entry is only eligible one cycle later.
  always_comb begin
    alloc_oh = '0;
    rdy_oh   = '0;
    found_a  = 1'b0;
    found_s  = 1'b0;
    sel_idx  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!e_busy[i] && !found_a) begin
        alloc_oh[i] = 1'b1;
        found_a     = 1'b1;
      end
      if (e_rdy[i] && !found_s) begin
        rdy_oh[i] = 1'b1;
        sel_idx   = IDX_W'(i);
        found_s   = 1'b1;
      end
    end
  end

  assign disp_ready = (occ_q != OCC_W'(RS_SIZE));
  assign disp_fire  = rs.i_disp_valid && disp_ready;
  assign wr_en      = alloc_oh & {RS_SIZE{disp_fire}};
  assign sel_en     = !iss_q.valid || rs.i_issue_ready;
  assign sel_any    = found_s && sel_en;
  assign sel_oh     = rdy_oh & {RS_SIZE{sel_en}};

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    rs_entry #(
      .REG_SIZE(REG_SIZE), .GPR_IDX_SIZE(GPR_IDX_SIZE), .OPC_SIZE(OPC_SIZE)
    ) u_ent (
      .clk          (i_clk),
      .clr          (clr),
      .wr_en        (wr_en[g]),
      .sel          (sel_oh[g]),
      .wr_opc       (rs.i_disp_opc),
      .wr_dst       (rs.i_disp_dst),
      .wr_op1_valid (rs.i_disp_op1_valid),
      .wr_op1_idx   (rs.i_disp_op1_gpr_idx),
      .wr_op1_value (rs.i_disp_op1_value),
      .wr_op2_valid (rs.i_disp_op2_valid),
      .wr_op2_idx   (rs.i_disp_op2_gpr_idx),
      .wr_op2_value (rs.i_disp_op2_value),
      .cdb_valid    (rs.i_cdb_valid),
      .cdb_idx      (rs.i_cdb_gpr_idx),
      .cdb_value    (rs.i_cdb_value),
      .busy         (e_busy[g]),
      .ready        (e_rdy[g]),
      .opc          (e_opc[g]),
      .dst          (e_dst[g]),
      .op1_value    (e_op1[g]),
      .op2_value    (e_op2[g])
    );
  end

  always_comb begin
    iss_d = iss_q;
    if (iss_q.valid && rs.i_issue_ready) iss_d.valid = 1'b0;
    if (sel_any) begin
      iss_d.valid = 1'b1;
      iss_d.opc   = e_opc[sel_idx];
      iss_d.dst   = e_dst[sel_idx];
      iss_d.op1   = e_op1[sel_idx];
      iss_d.op2   = e_op2[sel_idx];
    end
    occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(sel_any);
  end

  always_ff @(posedge i_clk) begin
    if (clr) begin
      iss_q <= '0;
      occ_q <= '0;
    end else begin
      iss_q <= iss_d;
      occ_q <= occ_d;
    end
  end

  assign rs.o_disp_ready  = disp_ready;
  assign rs.o_issue_valid = iss_q.valid;
  assign rs.o_issue_opc   = iss_q.opc;
  assign rs.o_issue_dst   = iss_q.dst;
  assign rs.o_issue_op1   = iss_q.op1;
  assign rs.o_issue_op2   = iss_q.op2;
  assign o_occupancy      = occ_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed vector table, hand sequences and a randomized run against an
// entry-list model of the reservation station.
module tb_reservation_station;
  localparam int RS = 2;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic [1:0] occ;
  int checks = 0, errors = 0, step = 0;

  always #5 clk = ~clk;

  reservation_station_if #(.REG_SIZE(64), .GPR_IDX_SIZE(5), .OPC_SIZE(4)) bus ();

  reservation_station #(.RS_SIZE(RS), .REG_SIZE(64), .GPR_IDX_SIZE(5), .OPC_SIZE(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .rs(bus.slave), .o_occupancy(occ)
  );

  typedef struct {
    bit rst, fl, rdy, dv; int dst; bit v1; longint a1; bit v2; longint a2;
    bit cv; int ct; longint cx;
    bit eiv; int eocc; bit edr; int edst; longint e1, e2;
  } vec_t;

  function automatic vec_t mk(bit r, bit f, bit rdy, bit dv, int dst, bit v1, longint a1,
                              bit v2, longint a2, bit cv, int ct, longint cx, bit eiv,
                              int eocc, bit edr, int edst, longint e1, longint e2);
    return '{r, f, rdy, dv, dst, v1, a1, v2, a2, cv, ct, cx, eiv, eocc, edr, edst, e1, e2};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
    end
  endtask

  // Operand field a doubles as tag (when pending) and value (when present).
  task automatic drive(bit r, bit f, bit rdy, bit dv, int dst, bit v1, longint a1,
                       bit v2, longint a2, bit cv, int ct, longint cx);
    rst = r; flush = f;
    bus.i_issue_ready      = rdy;
    bus.i_disp_valid       = dv;
    bus.i_disp_opc         = 4'(dst + 1);
    bus.i_disp_dst         = 5'(dst);
    bus.i_disp_op1_valid   = v1;
    bus.i_disp_op1_gpr_idx = 5'(a1);
    bus.i_disp_op1_value   = 64'(a1);
    bus.i_disp_op2_valid   = v2;
    bus.i_disp_op2_gpr_idx = 5'(a2);
    bus.i_disp_op2_value   = 64'(a2);
    bus.i_cdb_valid        = cv;
    bus.i_cdb_gpr_idx      = 5'(ct);
    bus.i_cdb_value        = 64'(cx);
  endtask

  task automatic apply(input vec_t t);
    drive(t.rst, t.fl, t.rdy, t.dv, t.dst, t.v1, t.a1, t.v2, t.a2, t.cv, t.ct, t.cx);
    @(posedge clk); #1;
    step++;
    chk("issue_valid", 64'(bus.o_issue_valid), 64'(t.eiv));
    chk("occupancy", 64'(occ), 64'(t.eocc));
    chk("disp_ready", 64'(bus.o_disp_ready), 64'(t.edr));
    if (t.eiv || t.rst || t.fl) begin
      chk("issue_opc", 64'(bus.o_issue_opc), t.eiv ? 64'(t.edst + 1) : 64'd0);
      chk("issue_dst", 64'(bus.o_issue_dst), 64'(t.edst));
      chk("issue_op1", bus.o_issue_op1, 64'(t.e1));
      chk("issue_op2", bus.o_issue_op2, 64'(t.e2));
    end
  endtask

  // Model: an array of entry records plus the held issue record.
  typedef struct {
    bit busy; logic [3:0] opc; logic [4:0] dst;
    bit v1; logic [4:0] t1; logic [63:0] x1;
    bit v2; logic [4:0] t2; logic [63:0] x2;
  } ment_t;
  ment_t m[RS];
  ment_t mo;
  bit    miv;

  function automatic ment_t wake(ment_t e, bit cv, logic [4:0] ct, logic [63:0] cx);
    if (cv && !e.v1 && e.t1 == ct) begin e.v1 = 1; e.x1 = cx; end
    if (cv && !e.v2 && e.t2 == ct) begin e.v2 = 1; e.x2 = cx; end
    return e;
  endfunction

  function automatic int busy_count();
    int n = 0;
    foreach (m[i]) if (m[i].busy) n++;
    return n;
  endfunction

  task automatic model_step();
    ment_t old[RS];
    int cnt, sel, al;
    if (rst || flush) begin
      foreach (m[i]) m[i].busy = 0;
      miv = 0;
      return;
    end
    old = m;
    cnt = busy_count();
    sel = -1;
    if (!miv || bus.i_issue_ready)
      foreach (old[i]) if (sel < 0 && old[i].busy && old[i].v1 && old[i].v2) sel = i;
    if (miv && bus.i_issue_ready) miv = 0;
    if (sel >= 0) begin miv = 1; mo = old[sel]; m[sel].busy = 0; end
    if (bus.i_disp_valid && cnt < RS) begin
      al = -1;
      foreach (old[i]) if (al < 0 && !old[i].busy) al = i;
      m[al] = '{1, bus.i_disp_opc, bus.i_disp_dst,
                bus.i_disp_op1_valid, bus.i_disp_op1_gpr_idx, bus.i_disp_op1_value,
                bus.i_disp_op2_valid, bus.i_disp_op2_gpr_idx, bus.i_disp_op2_value};
    end
    foreach (m[i])
      if (m[i].busy) m[i] = wake(m[i], bus.i_cdb_valid, bus.i_cdb_gpr_idx, bus.i_cdb_value);
  endtask

  vec_t tbl[16];

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed table: reset, valid dispatch, delayed wakeup, bypass, stale tag.
    tbl[0]  = mk(1,0,1, 0,0, 0,0,     0,0, 0,0,0,       0,0,1, 0,0,0);
    tbl[1]  = mk(0,0,1, 1,3, 1,5,     1,7, 0,0,0,       0,1,1, 0,0,0);
    tbl[2]  = mk(0,0,1, 0,0, 0,0,     0,0, 0,0,0,       1,0,1, 3,5,7);
    tbl[3]  = mk(0,0,1, 0,0, 0,0,     0,0, 0,0,0,       0,0,1, 0,0,0);
    tbl[4]  = mk(0,0,1, 1,6, 0,9,     1,1, 0,0,0,       0,1,1, 0,0,0);
    tbl[5]  = mk(0,0,1, 0,0, 0,0,     0,0, 0,0,0,       0,1,1, 0,0,0);
    tbl[6]  = mk(0,0,1, 0,0, 0,0,     0,0, 0,0,0,       0,1,1, 0,0,0);
    tbl[7]  = mk(0,0,1, 0,0, 0,0,     0,0, 1,9,'h1234,  0,1,1, 0,0,0);
    tbl[8]  = mk(0,0,1, 0,0, 0,0,     0,0, 0,0,0,       1,0,1, 6,'h1234,1);
    tbl[9]  = mk(0,0,1, 0,0, 0,0,     0,0, 0,0,0,       0,0,1, 0,0,0);
    tbl[10] = mk(0,0,1, 1,1, 0,4,     1,8, 1,4,42,      0,1,1, 0,0,0);
    tbl[11] = mk(0,0,1, 0,0, 0,0,     0,0, 0,0,0,       1,0,1, 1,42,8);
    tbl[12] = mk(0,0,1, 0,0, 0,0,     0,0, 0,0,0,       0,0,1, 0,0,0);
    tbl[13] = mk(0,0,1, 1,2, 1,3,     0,3, 1,3,99,      0,1,1, 0,0,0);
    tbl[14] = mk(0,0,1, 0,0, 0,0,     0,0, 0,0,0,       1,0,1, 2,3,99);
    tbl[15] = mk(0,0,1, 0,0, 0,0,     0,0, 0,0,0,       0,0,1, 0,0,0);
    for (int i = 0; i < 16; i++) apply(tbl[i]);

    // Fill with waiting ops, drop a third, wake both with one CDB, stall output.
    apply(mk(1,0,0, 0,0, 0,0,    0,0,    0,0,0,       0,0,1, 0,0,0));
    apply(mk(0,0,0, 1,1, 0,10,   1,100,  0,0,0,       0,1,1, 0,0,0));
    apply(mk(0,0,0, 1,2, 0,10,   1,200,  0,0,0,       0,2,0, 0,0,0));
    apply(mk(0,0,0, 1,3, 1,5,    1,6,    0,0,0,       0,2,0, 0,0,0));
    apply(mk(0,0,0, 0,0, 0,0,    0,0,    1,10,'h55,   0,2,0, 0,0,0));
    for (int i = 0; i < 4; i++)
      apply(mk(0,0,0, 0,0, 0,0,  0,0,    0,0,0,       1,1,1, 1,'h55,100));
    apply(mk(0,0,1, 0,0, 0,0,    0,0,    0,0,0,       1,0,1, 2,'h55,200));
    apply(mk(0,0,1, 0,0, 0,0,    0,0,    0,0,0,       0,0,1, 0,0,0));
    apply(mk(0,0,1, 0,0, 0,0,    0,0,    0,0,0,       0,0,1, 0,0,0));

    // Dispatch against a full station while it selects: occupancy 2,1,2.
    apply(mk(1,0,1, 0,0, 0,0,    0,0,    0,0,0,       0,0,1, 0,0,0));
    apply(mk(0,0,1, 1,1, 0,13,   1,1,    0,0,0,       0,1,1, 0,0,0));
    apply(mk(0,0,1, 1,2, 0,14,   1,2,    0,0,0,       0,2,0, 0,0,0));
    apply(mk(0,0,1, 0,0, 0,0,    0,0,    1,13,'h77,   0,2,0, 0,0,0));
    apply(mk(0,0,1, 1,3, 1,'h30, 1,'h31, 0,0,0,       1,1,1, 1,'h77,1));
    apply(mk(0,0,1, 1,3, 1,'h30, 1,'h31, 0,0,0,       0,2,0, 0,0,0));
    apply(mk(0,0,1, 0,0, 0,0,    0,0,    1,14,'h88,   1,1,1, 3,'h30,'h31));
    apply(mk(0,0,1, 0,0, 0,0,    0,0,    0,0,0,       1,0,1, 2,'h88,2));
    apply(mk(0,0,1, 0,0, 0,0,    0,0,    0,0,0,       0,0,1, 0,0,0));

    // Flush with a held op and busy entries; later CDB must not issue anything.
    apply(mk(1,0,0, 0,0, 0,0,    0,0,    0,0,0,       0,0,1, 0,0,0));
    apply(mk(0,0,0, 1,1, 1,'h11, 1,'h12, 0,0,0,       0,1,1, 0,0,0));
    apply(mk(0,0,0, 1,2, 0,15,   1,'h22, 0,0,0,       1,1,1, 1,'h11,'h12));
    apply(mk(0,0,0, 1,3, 0,15,   1,'h33, 0,0,0,       1,2,0, 1,'h11,'h12));
    apply(mk(0,1,1, 1,4, 1,1,    1,2,    1,15,'h99,   0,0,1, 0,0,0));
    apply(mk(0,0,1, 0,0, 0,0,    0,0,    1,15,'h99,   0,0,1, 0,0,0));
    apply(mk(0,0,1, 0,0, 0,0,    0,0,    0,0,0,       0,0,1, 0,0,0));
    apply(mk(0,0,1, 0,0, 0,0,    0,0,    0,0,0,       0,0,1, 0,0,0));

    // Randomized run against the model.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_step();
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 31)),
            $urandom_range(0, 2) == 0, longint'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, longint'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 4, int'($urandom_range(0, 3)), longint'($urandom));
      if (bus.i_disp_op1_valid) bus.i_disp_op1_value = {$urandom, $urandom};
      if (bus.i_disp_op2_valid) bus.i_disp_op2_value = {$urandom, $urandom};
      bus.i_disp_opc = 4'($urandom);
      model_step();
      @(posedge clk); #1;
      step++;
      chk("rnd_issue_valid", 64'(bus.o_issue_valid), 64'(miv));
      chk("rnd_occupancy", 64'(occ), 64'(busy_count()));
      chk("rnd_disp_ready", 64'(bus.o_disp_ready), 64'(busy_count() != RS));
      if (miv) begin
        chk("rnd_opc_dst", 64'({bus.o_issue_opc, bus.o_issue_dst}), 64'({mo.opc, mo.dst}));
        chk("rnd_op1", bus.o_issue_op1, mo.x1);
        chk("rnd_op2", bus.o_issue_op2, mo.x2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
